// File: rtl/wt_dcache_repl_ctrl.sv
// SRRIP replacement-state update sequencer for the write-through dcache.
// Arbitrates miss insertions, buffered hit promotions and flush sweeps.
module wt_dcache_repl_ctrl #(
  parameter int IDX_W     = 8,
  parameter int WAY_W     = 2,
  parameter int NUM_SETS  = 256,
  parameter int HIT_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  output logic             flush_ack_o,
  input  logic             hit_valid_i,
  input  logic [IDX_W-1:0] hit_idx_i,
  input  logic [WAY_W-1:0] hit_way_i,
  input  logic             miss_req_i,
  input  logic [IDX_W-1:0] miss_idx_i,
  output logic             miss_gnt_o,
  output logic [WAY_W-1:0] miss_way_o,
  output logic             upd_miss_o,
  output logic [IDX_W-1:0] upd_miss_idx_o,
  output logic             upd_hit_o,
  output logic [IDX_W-1:0] upd_hit_idx_o,
  output logic [WAY_W-1:0] upd_hit_way_o,
  output logic             upd_clr_o,
  output logic [IDX_W-1:0] upd_clr_idx_o,
  input  logic [WAY_W-1:0] repl_way_i,
  output logic             busy_o,
  output logic [7:0]       hit_drop_cnt_o
);

  localparam int PTR_W = $clog2(HIT_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(HIT_DEPTH);
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS-1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [WAY_W-1:0] way;
  } hit_t;

  state_e           state_q;
  logic [IDX_W-1:0] clr_cnt_q;
  hit_t             mem_q [HIT_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic [7:0]       drop_q;

  logic idle;
  logic empty;
  logic full;
  logic do_miss;
  logic do_pop;
  logic do_push;
  logic do_drop;
  logic flush_go;
  hit_t head;

  assign idle     = (state_q == IDLE);
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);
  assign head     = mem_q[rd_ptr_q];
  // Combinational grant paths are masked so reset forces every output low.
  assign do_miss  = rst_ni & idle & miss_req_i;
  assign do_pop   = rst_ni & idle & ~miss_req_i & ~empty;
  assign do_push  = idle & hit_valid_i & (~full | do_pop);
  assign do_drop  = idle & hit_valid_i & full & ~do_pop;
  assign flush_go = idle & flush_i;

  assign miss_gnt_o     = do_miss;
  assign miss_way_o     = do_miss ? repl_way_i : '0;
  assign upd_miss_o     = do_miss;
  assign upd_miss_idx_o = do_miss ? miss_idx_i : '0;
  assign upd_hit_o      = do_pop;
  assign upd_hit_idx_o  = do_pop ? head.idx : '0;
  assign upd_hit_way_o  = do_pop ? head.way : '0;
  assign upd_clr_o      = (state_q == SWEEP);
  assign upd_clr_idx_o  = clr_cnt_q;
  assign flush_ack_o    = (state_q == DONE);
  assign busy_o         = ~idle;
  assign hit_drop_cnt_o = drop_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_i) state_q <= SWEEP;
        end
        SWEEP: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_SET) state_q <= DONE;
        end
        DONE: begin
          clr_cnt_q <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_go) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= '{idx: hit_idx_i, way: hit_way_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_q <= '0;
    end else if (do_drop && drop_q != 8'hFF) begin
      drop_q <= drop_q + 1'b1;
    end
  end

endmodule
